// File: rtl/spi_config_sequencer.sv
// -----------------------------------------------------------------------------
// spi_config_sequencer
// Replays a host-loaded table of SPI register transactions into the SPI
// master's 35-bit request stream, one transaction outstanding at a time.
// Reads consume a 32-bit response, which produces a readback pulse and checks
// the echoed address. A read with no response before the timeout aborts the
// sequence. Each entry carries a settle delay that is applied before the next
// request.
//
// Ports
//   clk_serial, reset         clock, synchronous active-high reset
//   tbl_wr_en/addr/wdata      table load port, {delay[7:0], request[34:0]}, IDLE only
//   start, num_entries        launch a sequence of num_entries entries
//   busy, done                state != IDLE; one-cycle end-of-sequence pulse
//   error, err_code           sticky first error: 1 addr mismatch, 2 timeout
//   req_valid/ready/data      request stream to the SPI master
//   resp_valid/ready/data     response stream, {addr[15:0], data[15:0]}
//   rb_valid/index/data       readback pulse with table index and data
// -----------------------------------------------------------------------------
module spi_config_sequencer #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic          clk_serial,
    input  logic          reset,
    input  logic          tbl_wr_en,
    input  logic [AW-1:0] tbl_addr,
    input  logic [42:0]   tbl_wdata,
    input  logic          start,
    input  logic [AW:0]   num_entries,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [34:0]   req_data,
    input  logic          resp_valid,
    output logic          resp_ready,
    input  logic [31:0]   resp_data,
    output logic          rb_valid,
    output logic [AW-1:0] rb_index,
    output logic [15:0]   rb_data
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_RESP, S_DELAY, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   n_q, n_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          error_q, error_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          rb_valid_q, rb_valid_d;
    logic [AW-1:0] rb_index_q, rb_index_d;
    logic [15:0]   rb_data_q, rb_data_d;

    logic [42:0]   tbl_q [DEPTH];
    logic [42:0]   cur;

    // Transaction table; contents are not reset and only loadable while idle.
    always_ff @(posedge clk_serial) begin
        if (tbl_wr_en && (state_q == S_IDLE)) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    assign cur      = tbl_q[idx_q];
    assign req_data = cur[34:0];

    // State and sequencing registers.
    always_ff @(posedge clk_serial) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            rb_valid_q <= 1'b0;
            rb_index_q <= '0;
            rb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            rb_valid_q <= rb_valid_d;
            rb_index_q <= rb_index_d;
            rb_data_q  <= rb_data_d;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        rb_valid_d = 1'b0;
        rb_index_d = rb_index_q;
        rb_data_d  = rb_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d        = (num_entries > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_entries;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = (num_entries == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_ready) begin
                    if (cur[34]) begin
                        timer_d = '0;
                        state_d = S_WAIT_RESP;
                    end else begin
                        cnt_d   = cur[42:35];
                        state_d = S_DELAY;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (resp_valid) begin
                    rb_valid_d = 1'b1;
                    rb_index_d = idx_q;
                    // Single-data-byte reads return only the low byte.
                    rb_data_d  = {cur[32] ? resp_data[15:8] : 8'h00, resp_data[7:0]};
                    if ((resp_data[31:16] != cur[31:16]) && (err_code_q == ERR_NONE)) begin
                        error_d    = 1'b1;
                        err_code_d = ERR_ADDR;
                    end
                    cnt_d   = cur[42:35];
                    state_d = S_DELAY;
                end else if (timer_q == TW'(TIMEOUT - 2)) begin
                    // Timer would reach TIMEOUT-1 this cycle: abort the sequence.
                    error_d = 1'b1;
                    if (err_code_q == ERR_NONE) begin
                        err_code_d = ERR_TIMEOUT;
                    end
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DELAY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if ((AW+1)'(idx_q) == (n_q - (AW+1)'(1))) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        unique case (state_q)
            S_IDLE:      busy = 1'b0;
            S_ISSUE:     begin busy = 1'b1; req_valid  = 1'b1; end
            S_WAIT_RESP: begin busy = 1'b1; resp_ready = 1'b1; end
            S_DELAY:     busy = 1'b1;
            S_DONE:      begin busy = 1'b1; done = 1'b1; end
            default:     busy = 1'b0;
        endcase
    end

    assign error    = error_q;
    assign err_code = err_code_q;
    assign rb_valid = rb_valid_q;
    assign rb_index = rb_index_q;
    assign rb_data  = rb_data_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Directed bench for spi_config_sequencer (DEPTH=16, TIMEOUT=16).
module tb_spi_config_sequencer;

    localparam int unsigned AW = 4;

    logic          clk_serial = 1'b0;
    logic          reset;
    logic          tbl_wr_en;
    logic [AW-1:0] tbl_addr;
    logic [42:0]   tbl_wdata;
    logic          start;
    logic [AW:0]   num_entries;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic          req_valid, req_ready;
    logic [34:0]   req_data;
    logic          resp_valid, resp_ready;
    logic [31:0]   resp_data;
    logic          rb_valid;
    logic [AW-1:0] rb_index;
    logic [15:0]   rb_data;

    int checks = 0;
    int errors = 0;
    logic [42:0] exp_tbl [16];

    spi_config_sequencer #(.DEPTH(16), .TIMEOUT(16)) dut (
        .clk_serial (clk_serial),
        .reset      (reset),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_addr   (tbl_addr),
        .tbl_wdata  (tbl_wdata),
        .start      (start),
        .num_entries(num_entries),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .rb_valid   (rb_valid),
        .rb_index   (rb_index),
        .rb_data    (rb_data)
    );

    always #5 clk_serial = ~clk_serial;

    task automatic tick();
        @(posedge clk_serial);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [42:0] ent(input logic [7:0] dly, input logic rd, input logic ab,
                                        input logic db, input logic [15:0] a, input logic [15:0] d);
        return {dly, rd, ab, db, a, d};
    endfunction

    task automatic wr(input int i, input logic [42:0] w);
        tbl_wr_en = 1'b1;
        tbl_addr  = AW'(i);
        tbl_wdata = w;
        exp_tbl[i] = w;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic go(input int n);
        start       = 1'b1;
        num_entries = (AW+1)'(n);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        int bad;
        int cyc;
        logic seen_req;
        logic seen_done;

        reset = 1'b1; tbl_wr_en = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        start = 1'b0; num_entries = '0; req_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0;
        tick(); tick();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req_valid", 64'(req_valid), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd0);
        chk("rst_err", 64'({error, err_code}), 64'd0);
        chk("rst_rb", 64'({rb_valid, rb_index, rb_data}), 64'd0);
        reset = 1'b0;

        // Three writes, delay 0: requests every other cycle, then done
        for (int i = 0; i < 3; i++) wr(i, ent(8'd0, 1'b0, 1'b1, 1'b0, 16'(16'h0012 + i), 16'(16'h0034 + i)));
        req_ready = 1'b1;
        go(3);
        chk("w_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("w_req_valid", 64'(req_valid), 64'd1);
            chk("w_req_data", 64'(req_data), 64'(exp_tbl[i][34:0]));
            tick();
            chk("w_gap_no_req", 64'(req_valid), 64'd0);
            tick();
        end
        chk("w_done", 64'(done), 64'd1);
        chk("w_done_busy", 64'(busy), 64'd1);
        chk("w_error", 64'(error), 64'd0);
        tick();
        chk("w_idle_busy", 64'(busy), 64'd0);
        chk("w_done_pulse", 64'(done), 64'd0);

        // Single-byte read with delay 3, response after 5 cycles
        wr(0, ent(8'd3, 1'b1, 1'b1, 1'b0, 16'h1A2B, 16'h0000));
        go(1);
        chk("r_req_data", 64'(req_data), 64'(exp_tbl[0][34:0]));
        tick();
        chk("r_resp_ready", 64'(resp_ready), 64'd1);
        chk("r_no_req_wait", 64'(req_valid), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        resp_valid = 1'b1; resp_data = 32'h1A2B_FF5C;
        tick();
        resp_valid = 1'b0;
        chk("r_rb_valid", 64'(rb_valid), 64'd1);
        chk("r_rb_index", 64'(rb_index), 64'd0);
        chk("r_rb_data", 64'(rb_data), 64'h005C);
        chk("r_resp_ready_off", 64'(resp_ready), 64'd0);
        chk("r_error", 64'(error), 64'd0);
        tick();
        chk("r_rb_pulse", 64'(rb_valid), 64'd0);
        tick(); tick();
        chk("r_done_early", 64'(done), 64'd0);
        // done on the fifth cycle counting the readback cycle (4 DELAY + DONE)
        tick();
        chk("r_done", 64'(done), 64'd1);
        tick();

        // Address-echo mismatch on entry 1; entry 2 still issued
        wr(0, ent(8'd0, 1'b0, 1'b1, 1'b1, 16'h0050, 16'h0077));
        wr(1, ent(8'd0, 1'b1, 1'b1, 1'b1, 16'h0040, 16'h0000));
        wr(2, ent(8'd0, 1'b0, 1'b1, 1'b1, 16'h0060, 16'h0088));
        go(3);
        tick(); tick();
        chk("m_req1", 64'(req_data), 64'(exp_tbl[1][34:0]));
        tick();
        resp_valid = 1'b1; resp_data = 32'h0041_ABCD;
        tick();
        resp_valid = 1'b0;
        chk("m_rb_index", 64'(rb_index), 64'd1);
        chk("m_rb_data", 64'(rb_data), 64'hABCD);
        chk("m_error", 64'(error), 64'd1);
        chk("m_err_code", 64'(err_code), 64'd1);
        tick();
        chk("m_req2_valid", 64'(req_valid), 64'd1);
        chk("m_req2", 64'(req_data), 64'(exp_tbl[2][34:0]));
        tick(); tick();
        chk("m_done", 64'(done), 64'd1);
        tick();
        chk("m_err_hold", 64'({error, err_code}), 64'({1'b1, 2'd1}));

        // Read timeout aborts; later entry never issued
        wr(0, ent(8'd0, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h0000));
        wr(1, ent(8'd0, 1'b0, 1'b1, 1'b1, 16'h0110, 16'h0011));
        go(2);
        chk("t_err_cleared", 64'({error, err_code}), 64'd0);
        seen_req = 1'b0; seen_done = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (req_valid) seen_req = 1'b1;
            if (done) seen_done = 1'b1;
        end
        chk("t_no_early_done", 64'(seen_done), 64'd0);
        chk("t_no_req", 64'(seen_req), 64'd0);
        tick();
        chk("t_done_at_16", 64'(done), 64'd1);
        chk("t_err_code", 64'({error, err_code}), 64'({1'b1, 2'd2}));
        tick();
        chk("t_err_hold", 64'(err_code), 64'd2);

        // N=0: done next cycle, no request, error cleared
        go(0);
        chk("z_done", 64'(done), 64'd1);
        chk("z_no_req", 64'(req_valid), 64'd0);
        chk("z_err_cleared", 64'({error, err_code}), 64'd0);
        tick();
        chk("z_idle", 64'(busy), 64'd0);

        // N=20 clamps to 16; start and table writes while busy ignored
        for (int i = 0; i < 16; i++) wr(i, ent(8'd0, 1'b0, 1'b0, 1'b1, 16'(16'h0200 + i), 16'(i)));
        go(20);
        cnt = 0; bad = 0; cyc = 0;
        while (!done && cyc < 100) begin
            if (req_valid) begin
                if (cnt > 15 || req_data !== exp_tbl[cnt][34:0]) bad++;
                cnt++;
            end
            tbl_wr_en   = (cyc == 1 || cyc == 3);
            tbl_addr    = '0;
            tbl_wdata   = 43'h7_FFFF_FFFF;
            start       = (cyc == 2);
            num_entries = 5'd1;
            tick();
            cyc++;
        end
        tbl_wr_en = 1'b0; start = 1'b0;
        chk("c_done_seen", 64'(done), 64'd1);
        chk("c_req_count", 64'(cnt), 64'd16);
        chk("c_req_order", 64'(bad), 64'd0);
        tick();
        go(1);
        chk("c_tbl_unchanged", 64'(req_data), 64'(exp_tbl[0][34:0]));
        tick(); tick(); tick();
        chk("c_idle", 64'(busy), 64'd0);

        // Reset in WAIT_RESP, then a clean rerun from index 0
        wr(0, ent(8'd0, 1'b1, 1'b1, 1'b1, 16'h0300, 16'h0000));
        go(2);
        tick();
        chk("x_in_wait", 64'(resp_ready), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("x_busy", 64'(busy), 64'd0);
        chk("x_done", 64'(done), 64'd0);
        chk("x_hs", 64'({req_valid, resp_ready}), 64'd0);
        chk("x_err", 64'({error, err_code}), 64'd0);
        chk("x_rb", 64'({rb_valid, rb_index, rb_data}), 64'd0);
        tick();
        chk("x_no_done", 64'({busy, done}), 64'd0);
        go(2);
        chk("x_req0", 64'(req_data), 64'(exp_tbl[0][34:0]));
        tick();
        resp_valid = 1'b1; resp_data = 32'h0300_1234;
        tick();
        resp_valid = 1'b0;
        chk("x_rb", 64'({rb_valid, rb_index, rb_data}), 64'({1'b1, 4'd0, 16'h1234}));
        tick();
        chk("x_req1", 64'(req_data), 64'(exp_tbl[1][34:0]));
        tick(); tick();
        chk("x_done_end", 64'({done, error}), 64'({1'b1, 1'b0}));
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
